// File: rtl/button_conditioner.sv
// Button conditioner: per-channel 2-flop sync, debounce, and press/release/tap/long strobes.
// Optional auto-repeat strobes are built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 15_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] tap_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_held
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    // Zero-length timers would make the counters meaningless.
    generate
        if (N_BTN == 0 || DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_cfg
            $error("button_conditioner: all parameters must be non-zero");
        end
    endgenerate

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e            state_q;
        logic [1:0]        sync_q;
        logic              btn_s;
        logic              level_q;
        logic              level_d;
        logic [DEB_W-1:0]  deb_q;
        logic [DEB_W-1:0]  deb_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_inc;
        logic              press_q;
        logic              release_q;
        logic              tap_q;
        logic              long_q;
        logic              rise;
        logic              fall;

        assign btn_s    = sync_q[1];
        assign hold_inc = hold_q + HOLD_W'(1);
        assign rise     = level_d & ~level_q;
        assign fall     = ~level_d & level_q;

        // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            deb_d   = '0;
            level_d = level_q;
            if (btn_s != level_q) begin
                if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = ~level_q;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [REP_W-1:0] rep_q;
        logic [REP_W-1:0] rep_d;
        logic             repeat_q;

        assign rep_d = (rep_q == REP_W'(REPEAT_CYCLES - 1)) ? '0 : rep_q + REP_W'(1);
        assign repeat_pulse[i] = repeat_q;
`else
        assign repeat_pulse[i] = 1'b0;
`endif

        // Sync chain, debounce state and hold FSM with registered strobes.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= ST_IDLE;
                sync_q    <= '0;
                level_q   <= 1'b0;
                deb_q     <= '0;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                tap_q     <= 1'b0;
                long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rep_q     <= '0;
                repeat_q  <= 1'b0;
`endif
            end else begin
                sync_q    <= {sync_q[0], btn_raw[i]};
                deb_q     <= deb_d;
                level_q   <= level_d;
                press_q   <= rise;
                release_q <= fall;
                tap_q     <= 1'b0;
                long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                repeat_q  <= 1'b0;
`endif
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            hold_q <= '0;
                            if (LONG_CYCLES == 1) begin
                                long_q  <= 1'b1;
                                state_q <= ST_LONG;
`ifdef BTN_AUTOREPEAT_EN
                                rep_q   <= '0;
`endif
                            end else begin
                                state_q <= ST_HELD;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (fall) begin
                            tap_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q <= hold_inc;
                            if (hold_inc == HOLD_W'(LONG_CYCLES - 1)) begin
                                long_q  <= 1'b1;
                                state_q <= ST_LONG;
`ifdef BTN_AUTOREPEAT_EN
                                rep_q   <= '0;
`endif
                            end
                        end
                    end
                    ST_LONG: begin
                        // hold_q stays parked at its terminal value, so long fires once per hold.
                        if (fall) begin
                            state_q <= ST_IDLE;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else begin
                            rep_q    <= rep_d;
                            repeat_q <= (rep_d == REP_W'(REPEAT_CYCLES - 1));
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign tap_pulse[i]     = tap_q;
        assign long_pulse[i]    = long_q;
    end

    assign any_held = |btn_level;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the clock/timer/stopwatch/alarm top level.
- Converts N raw, bouncy, asynchronous push-button inputs (start_stop, mode, edit_shift, inc, reset-button) into clean single-cycle event strobes: press, tap, long-press and optional auto-repeat.
- The mode controller consumes these strobes directly, so it no longer needs its own per-mode hold-time counters or scount-style re-arming logic.

Parameters:
- N_BTN, 5, number of independent button channels; all channels are identical.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required before the debounced level changes (10 ms at 100 MHz).
- LONG_CYCLES, 15_000_000, cycles a button must stay held, counted from its press_pulse, before long_pulse fires.
- REPEAT_CYCLES, 10_000_000, auto-repeat period after long_pulse; used only with the optional feature.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw asynchronous button inputs, active-high.
- btn_level  output  N_BTN  debounced button level.
- press_pulse  output  N_BTN  one-cycle strobe on debounced rising edge.
- release_pulse  output  N_BTN  one-cycle strobe on debounced falling edge.
- tap_pulse  output  N_BTN  one-cycle strobe on release before long-press threshold.
- long_pulse  output  N_BTN  one-cycle strobe once per hold, when LONG_CYCLES is reached.
- repeat_pulse  output  N_BTN  one-cycle auto-repeat strobe while held past long.
- any_held  output  1  OR of btn_level.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
  - While reset is high, all outputs are 0, all counters are 0, synchronizer flops are 0 and every channel FSM is IDLE.
- Synchronizer:
  - 2-flop chain per channel.
  - btn_s is btn_raw delayed by 2 clk edges.
- Debounce (per channel):
  - deb_cnt counts consecutive cycles in which btn_s != btn_level.
  - Any cycle with btn_s == btn_level clears deb_cnt to 0.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and btn_s still differs, btn_level toggles on the next edge and deb_cnt clears.
  - Latency from a clean raw edge to btn_level change is exactly DEBOUNCE_CYCLES+2 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach btn_level.
- Strobes:
  - All strobes are registered and last exactly one cycle.
  - press_pulse is high in the first cycle btn_level reads 1.
  - release_pulse is high in the first cycle btn_level reads 0.
- Hold FSM per channel (states IDLE, HELD, LONG):
  - IDLE -> HELD on debounced rise; hold_cnt cleared to 0.
  - HELD: hold_cnt increments each cycle, starting at 0 in the press_pulse cycle.
  - HELD: at hold_cnt == LONG_CYCLES-1, long_pulse fires and the FSM goes to LONG; rep_cnt is cleared.
  - HELD -> IDLE on debounced fall: tap_pulse fires coincident with release_pulse.
  - LONG -> IDLE on debounced fall: release_pulse only, no tap_pulse.
  - long_pulse fires at most once per hold.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - hold_cnt and rep_cnt are $clog2 of their limits +1 bits.
  - hold_cnt saturates and never wraps: no second long_pulse on extremely long holds.
- Channel independence: channels are fully independent. Simultaneous presses on several channels produce simultaneous strobes; the block performs no arbitration or priority.
- Reset mid-operation:
  - All strobes are suppressed and the FSM returns to IDLE.
  - A button still held when reset deasserts is re-debounced: press_pulse arrives DEBOUNCE_CYCLES+2 cycles after reset falls, never earlier.
- any_held is combinational OR of the registered btn_level bits.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In LONG, rep_cnt increments every cycle, starting at 0 in the long_pulse cycle.
  - When rep_cnt == REPEAT_CYCLES-1, repeat_pulse fires and rep_cnt clears.
  - This repeats until release.
  - A release in the same cycle as the repeat terminal count suppresses that repeat_pulse.
- Not defined: repeat_pulse is constant 0 and rep_cnt and its logic are absent.
- All other behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, N_BTN=5):
- Clean press: btn_raw[3] 0->1 at cycle 10 and held -> btn_level[3] and press_pulse[3] high at cycle 16; press_pulse is low at cycle 17; no other channel toggles.
- Bounce: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays 1 -> zero press_pulse during bouncing; exactly one press_pulse 6 cycles after the final stable edge.
- Tap vs long:
  - Hold btn 0 for 10 cycles then release -> tap_pulse[0] and release_pulse[0] in the same cycle; long_pulse never fires.
  - Hold for 40 cycles -> long_pulse[0] exactly 19 cycles after press_pulse; release gives release_pulse only, no tap_pulse.
- Auto-repeat (BTN_AUTOREPEAT_EN defined): hold btn 2 for 60 cycles past press -> long_pulse at +19, repeat_pulse at +26, +34, +42, ...; none after release.
- Same stimulus with the macro undefined -> repeat_pulse stays 0 throughout.
- Reset mid-hold: btn 4 held, assert reset for 3 cycles at press+10 -> all outputs 0 during reset; no long_pulse; press_pulse reissued 6 cycles after reset deasserts; any_held follows btn_level.
- Simultaneous: btn_raw[0] and btn_raw[2] rise in the same cycle -> press_pulse[0] and press_pulse[2] high in the same cycle; any_held high from that cycle.
